// File: rtl/strobseq.sv
// Strobe sequencer: per-state strob1 width, optional gap + strob2 phase, got pulse extendable by zw&oken.
// Single-step mode parks in HOLD with strob1 high until a synchronised step edge or mode release.
module strobseq #(
  parameter int              N            = 5,
  parameter int              TW           = 4,
  parameter logic [N*TW-1:0] STROB1_TICKS = {N{4'd3}},
  parameter logic [N-1:0]    ST2_MASK     = 5'b00011,
  parameter logic [N-1:0]    OK_MASK      = 5'b00110,
  parameter int              GAP_TICKS    = 1,
  parameter int              STROB2_TICKS = 3,
  parameter int              GOT_TICKS    = 2,
  parameter int              IW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic          __clk,
  input  logic          rst_,
  input  logic [N-1:0]  ss,
  input  logic          ok,
  input  logic          zw,
  input  logic          oken,
  input  logic          mode,
  input  logic          step,
  input  logic          strob_fp,
  output logic          strob1,
  output logic          strob2,
  output logic          got,
  output logic          busy,
  output logic [IW-1:0] act_idx
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S1   = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] S2   = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;
  localparam logic [2:0] GOT  = 3'd5;

  function automatic logic ticks_legal();
    logic legal;
    legal = (GAP_TICKS >= 1) && (GAP_TICKS < 2**TW) &&
            (STROB2_TICKS >= 1) && (STROB2_TICKS < 2**TW) &&
            (GOT_TICKS >= 1) && (GOT_TICKS < 2**TW);
    for (int i = 0; i < N; i++)
      if (STROB1_TICKS[i*TW +: TW] == '0) legal = 1'b0;
    return legal;
  endfunction

  localparam logic TICKS_LEGAL = ticks_legal();

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx_nxt;
  logic [2:0]    step_sync;
  logic          strob1_q;

  logic          sel_vld;
  logic [IW-1:0] sel_idx;
  logic          start;
  logic          cnt_zero;
  logic          step_rise;
  logic [2:0]    tail_state;
  logic [TW-1:0] tail_cnt;

  // Lowest set select wins; its ok gate alone decides whether the cycle may start.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ss[i]) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign start     = sel_vld && (!OK_MASK[sel_idx] || ok);
  assign cnt_zero  = (cnt == '0);
  assign step_rise = step_sync[1] & ~step_sync[2];

  // Where the cycle goes once strob1 is finished (directly or via HOLD).
  assign tail_state = ST2_MASK[act_idx] ? GAP : GOT;
  assign tail_cnt   = ST2_MASK[act_idx] ? TW'(GAP_TICKS - 1) : TW'(GOT_TICKS - 1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = act_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = S1;
          cnt_nxt   = STROB1_TICKS[int'(sel_idx)*TW +: TW] - TW'(1);
          idx_nxt   = sel_idx;
        end
      end
      S1: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - TW'(1);
        end else if (mode) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = tail_state;
          cnt_nxt   = tail_cnt;
        end
      end
      HOLD: begin
        if (step_rise || !mode) begin
          state_nxt = tail_state;
          cnt_nxt   = tail_cnt;
        end
      end
      GAP: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - TW'(1);
        end else begin
          state_nxt = S2;
          cnt_nxt   = TW'(STROB2_TICKS - 1);
        end
      end
      S2: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - TW'(1);
        end else begin
          state_nxt = GOT;
          cnt_nxt   = TW'(GOT_TICKS - 1);
        end
      end
      GOT: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - TW'(1);
        end else if (zw && oken) begin
          cnt_nxt = TW'(GOT_TICKS - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they never glitch on decode.
  always_ff @(posedge __clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      cnt       <= '0;
      act_idx   <= '0;
      step_sync <= '0;
      strob1_q  <= 1'b0;
      strob2    <= 1'b0;
      got       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      act_idx   <= idx_nxt;
      step_sync <= {step_sync[1:0], step};
      strob1_q  <= (state_nxt == S1) || (state_nxt == HOLD);
      strob2    <= (state_nxt == S2);
      got       <= (state_nxt == GOT);
      busy      <= (state_nxt != IDLE);
    end
  end

  assign strob1 = strob1_q | strob_fp;

  a_ticks_legal: assert property (@(posedge __clk) disable iff (!rst_) TICKS_LEGAL);

endmodule

// File: tb/tb_strobseq.sv
// Bench for strobseq: reset, vector table, step/mode and reset-abort sequences, then random vs. queue model.
module tb_strobseq;
  localparam int N = 5;
  localparam int IW = 3;
  localparam int T1 = 3, GAPT = 1, S2T = 3, GOTT = 2;
  localparam logic [N-1:0] ST2M = 5'b00011;
  localparam logic [N-1:0] OKM  = 5'b00110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ = 1'b0;
  logic [N-1:0]  ss = '0;
  logic          ok = 1'b0, zw = 1'b0, oken = 1'b0, mode = 1'b0, step = 1'b0, strob_fp = 1'b0;
  logic          strob1, strob2, got, busy;
  logic [IW-1:0] act_idx;

  int tests = 0;
  int fails = 0;

  strobseq dut (
    .__clk(clk), .rst_(rst_), .ss(ss), .ok(ok), .zw(zw), .oken(oken), .mode(mode),
    .step(step), .strob_fp(strob_fp), .strob1(strob1), .strob2(strob2), .got(got),
    .busy(busy), .act_idx(act_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic s1, input logic s2, input logic g,
                       input logic b, input logic [IW-1:0] idx);
    tests++;
    if ({strob1, strob2, got, busy, act_idx} !== {s1, s2, g, b, idx}) begin
      fails++;
      $display("FAIL %s: actual s1=%b s2=%b got=%b busy=%b idx=%0d, required s1=%b s2=%b got=%b busy=%b idx=%0d",
               name, strob1, strob2, got, busy, act_idx, s1, s2, g, b, idx);
    end
  endtask

  // Per-cycle vectors: inputs applied before an edge, outputs expected just after it.
  typedef struct packed {
    logic [N-1:0]  ss;
    logic          ok, zw, oken, fp;
    logic          s1, s2, g, b;
    logic [IW-1:0] idx;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [N-1:0] v_ss, input logic v_ok, input logic v_zw,
                     input logic v_oken, input logic v_fp, input logic e_s1, input logic e_s2,
                     input logic e_g, input logic e_b, input logic [IW-1:0] e_idx, input int reps);
    vec_t v;
    v = '{ss: v_ss, ok: v_ok, zw: v_zw, oken: v_oken, fp: v_fp,
          s1: e_s1, s2: e_s2, g: e_g, b: e_b, idx: e_idx};
    for (int r = 0; r < reps; r++) tbl.push_back(v);
  endtask

  // Reference model: a queue of upcoming {strob1,strob2,got} values per clock, refilled at phase decisions.
  localparam int M_IDLE = 0, M_S1 = 1, M_HOLD = 2, M_TAIL = 3;
  logic [2:0]    mq[$];
  int            mph = M_IDLE;
  int            m_idx = 0;
  logic [2:0]    m_cur = 3'b000;

  task automatic push_n(input logic [2:0] code, input int n);
    for (int k = 0; k < n; k++) mq.push_back(code);
  endtask

  task automatic push_tail();
    if (ST2M[m_idx]) begin
      push_n(3'b000, GAPT);
      push_n(3'b010, S2T);
    end
    push_n(3'b001, GOTT);
  endtask

  task automatic model_edge();
    int sel;
    sel = -1;
    case (mph)
      M_IDLE: begin
        m_cur = 3'b000;
        for (int i = N - 1; i >= 0; i--) if (ss[i]) sel = i;
        if (sel >= 0 && (!OKM[sel] || ok)) begin
          m_idx = sel;
          push_n(3'b100, T1);
          mph = M_S1;
          m_cur = mq.pop_front();
        end
      end
      M_S1: begin
        if (mq.size() > 0) m_cur = mq.pop_front();
        else if (mode) begin mph = M_HOLD; m_cur = 3'b100; end
        else begin push_tail(); mph = M_TAIL; m_cur = mq.pop_front(); end
      end
      M_HOLD: begin
        if (!mode) begin push_tail(); mph = M_TAIL; m_cur = mq.pop_front(); end
        else m_cur = 3'b100;
      end
      default: begin
        if (mq.size() > 0) m_cur = mq.pop_front();
        else if (zw && oken) begin push_n(3'b001, GOTT); m_cur = mq.pop_front(); end
        else begin mph = M_IDLE; m_cur = 3'b000; end
      end
    endcase
  endtask

  initial begin
    // Reset held: selects and step toggle, nothing registered may rise.
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ss = N'($urandom_range(1, 31));
      step = ~step;
      tick();
      check("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    end
    strob_fp = 1'b1;
    #1 check("reset_fp", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    strob_fp = 1'b0; ss = '0; step = 1'b0; ok = 1'b0;
    rst_ = 1'b1;
    tick();
    check("reset_release", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Full cycle with strob2, ok-gated cycle, front panel, got extension, simultaneous selects.
    add(5'b00001, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(5'b00000, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(5'b00000, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(5'b00100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    add(5'b00100, 1, 0, 0, 0, 1, 0, 0, 1, 2, 1);
    add(5'b00000, 0, 0, 0, 0, 1, 0, 0, 1, 2, 2);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    add(5'b00000, 0, 0, 0, 1, 1, 0, 0, 0, 2, 1);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
    add(5'b01000, 0, 0, 0, 0, 1, 0, 0, 1, 3, 1);
    add(5'b00000, 0, 0, 0, 0, 1, 0, 0, 1, 3, 2);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 1, 1, 3, 1);
    add(5'b00000, 0, 1, 1, 0, 0, 0, 1, 1, 3, 3);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    add(5'b00011, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(5'b00000, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(5'b00000, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    foreach (tbl[i]) begin
      ss = tbl[i].ss; ok = tbl[i].ok; zw = tbl[i].zw; oken = tbl[i].oken; strob_fp = tbl[i].fp;
      tick();
      check($sformatf("table_row%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].g, tbl[i].b, tbl[i].idx);
    end
    ss = '0; ok = 1'b0; zw = 1'b0; oken = 1'b0; strob_fp = 1'b0;

    // Step mode, left by a step pulse: two sync flops plus edge detect before HOLD exits.
    mode = 1'b1; ok = 1'b1; ss = 5'b00010;
    tick(); check("step_s1", 1, 0, 0, 1, 1);
    ss = '0;
    for (int c = 0; c < 12; c++) begin tick(); check("step_hold", 1, 0, 0, 1, 1); end
    step = 1'b1;
    tick(); check("step_sync1", 1, 0, 0, 1, 1);
    tick(); check("step_sync2", 1, 0, 0, 1, 1);
    tick(); check("step_gap", 0, 0, 0, 1, 1);
    step = 1'b0;
    for (int c = 0; c < S2T; c++) begin tick(); check("step_s2", 0, 1, 0, 1, 1); end
    for (int c = 0; c < GOTT; c++) begin tick(); check("step_got", 0, 0, 1, 1, 1); end
    tick(); check("step_idle", 0, 0, 0, 0, 1);

    // Step mode, left by dropping mode.
    ss = 5'b00010;
    tick(); check("mdrop_s1", 1, 0, 0, 1, 1);
    ss = '0;
    for (int c = 0; c < 6; c++) begin tick(); check("mdrop_hold", 1, 0, 0, 1, 1); end
    mode = 1'b0;
    tick(); check("mdrop_gap", 0, 0, 0, 1, 1);
    for (int c = 0; c < S2T; c++) begin tick(); check("mdrop_s2", 0, 1, 0, 1, 1); end
    for (int c = 0; c < GOTT; c++) begin tick(); check("mdrop_got", 0, 0, 1, 1, 1); end
    tick(); check("mdrop_idle", 0, 0, 0, 0, 1);

    // Reset during strob2 aborts the cycle at once and no got follows.
    ss = 5'b00010;
    tick(); check("abort_s1", 1, 0, 0, 1, 1);
    ss = '0; ok = 1'b0;
    tick(); tick();
    tick(); check("abort_gap", 0, 0, 0, 1, 1);
    tick(); check("abort_s2", 0, 1, 0, 1, 1);
    rst_ = 1'b0;
    #1 check("abort_async", 0, 0, 0, 0, 0);
    tick(); check("abort_held", 0, 0, 0, 0, 0);
    rst_ = 1'b1;
    for (int c = 0; c < 6; c++) begin tick(); check("abort_no_got", 0, 0, 0, 0, 0); end

    // Random traffic against the queue model, starting from a fresh reset.
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    mq.delete(); mph = M_IDLE; m_idx = 0; m_cur = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        1:       ss = N'(1 << $urandom_range(0, N - 1));
        2:       ss = N'($urandom_range(0, 31));
        default: ss = '0;
      endcase
      ok       = 1'($urandom_range(0, 1));
      zw       = 1'($urandom_range(0, 1));
      oken     = 1'($urandom_range(0, 1));
      mode     = ($urandom_range(0, 5) == 0);
      strob_fp = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("random_c%0d", c), m_cur[2] | strob_fp, m_cur[1], m_cur[0],
            (mph != M_IDLE), IW'(m_idx));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
